// File: rtl/unalign_samples_if.sv
// AXI-Stream style sample bus shared by the input and output sides of unalign_samples.
// Carries the word, sideband, packet end marker and the valid-sample count of the last word.
interface unalign_samples_if #(
   parameter int SAMP_W = 32,
   parameter int SPC    = 4,
   parameter int USER_W = 1
);
   localparam int DATA_W  = SPC * SAMP_W;
   localparam int SHIFT_W = $clog2(SPC);

   logic [DATA_W-1:0]  tdata;
   logic [USER_W-1:0]  tuser;
   logic               tlast;
   logic [SHIFT_W-1:0] last_n;
   logic               tvalid;
   logic               tready;

   modport master (output tdata, tuser, tlast, last_n, tvalid, input tready);
   modport slave  (input tdata, tuser, tlast, last_n, tvalid, output tready);
endinterface

// File: rtl/unalign_samples.sv
// Strips the leading sample offset from each packet and repacks so the first kept sample lands in lane 0.
// Optional macro UNALIGN_SAMPLES_ZERO_PAD_EN zeroes unused lanes of every tlast beat.
module unalign_samples #(
   parameter int SAMP_W = 32,
   parameter int SPC    = 4,
   parameter int USER_W = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [$clog2(SPC)-1:0] i_offset,
   unalign_samples_if.slave       i_axis,
   unalign_samples_if.master      o_axis,
   output logic                   o_err
);
   localparam int DATA_W  = SPC * SAMP_W;
   localparam int SHIFT_W = $clog2(SPC);
   localparam logic [SHIFT_W:0]   SPC_N = (SHIFT_W+1)'(SPC);
   localparam logic [SHIFT_W+1:0] SPC_F = (SHIFT_W+2)'(SPC);

   typedef enum logic [1:0] {SOP = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_e;

   state_e              state_q, state_d;
   logic [SHIFT_W-1:0]  off_q, off_d;
   logic [DATA_W-1:0]   carry_q, carry_d;
   logic [SHIFT_W-1:0]  flush_n_q, flush_n_d;
   logic [USER_W-1:0]   flush_user_q, flush_user_d;
   logic [DATA_W-1:0]   o_tdata_q, o_tdata_d;
   logic [USER_W-1:0]   o_tuser_q, o_tuser_d;
   logic                o_tlast_q, o_tlast_d;
   logic [SHIFT_W-1:0]  o_last_n_q, o_last_n_d;
   logic                o_tvalid_q, o_tvalid_d;
   logic                o_err_q, o_err_d;

   logic                load, in_fire;
   logic [SHIFT_W-1:0]  cur_off;
   logic [SHIFT_W:0]    carry_cnt, n_full;
   logic [SHIFT_W+1:0]  fill_cnt;
   logic [DATA_W-1:0]   shifted, merged;
   logic                emit, e_last;
   logic [DATA_W-1:0]   e_data;
   logic [USER_W-1:0]   e_user;
   logic [SHIFT_W-1:0]  e_n;

`ifdef UNALIGN_SAMPLES_ZERO_PAD_EN
   function automatic logic [DATA_W-1:0] pad_lanes(input logic [DATA_W-1:0] d,
                                                   input logic [SHIFT_W-1:0] n);
      logic [DATA_W-1:0] r;
      r = d;
      for (int k = 0; k < SPC; k++) begin
         if (n != '0 && k >= int'(n)) r[k*SAMP_W +: SAMP_W] = '0;
      end
      return r;
   endfunction
`endif

   assign load            = !o_tvalid_q || o_axis.tready;
   assign i_axis.tready   = (state_q != FLUSH) && load;
   assign in_fire         = i_axis.tvalid && i_axis.tready;
   assign cur_off         = (state_q == SOP) ? i_offset : off_q;
   assign carry_cnt       = SPC_N - {1'b0, cur_off};
   assign n_full          = (i_axis.last_n == '0) ? SPC_N : {1'b0, i_axis.last_n};
   assign fill_cnt        = {1'b0, carry_cnt} + {1'b0, n_full};

   // shifted drops the leading offset lanes; merged appends the current beat after the carried samples
   always_comb begin
      shifted = '0;
      merged  = '0;
      for (int k = 0; k < SPC; k++) begin
         if (k + int'(cur_off) < SPC)
            shifted[k*SAMP_W +: SAMP_W] = i_axis.tdata[(k + int'(cur_off))*SAMP_W +: SAMP_W];
         if (k < int'(carry_cnt))
            merged[k*SAMP_W +: SAMP_W] = carry_q[k*SAMP_W +: SAMP_W];
         else
            merged[k*SAMP_W +: SAMP_W] = i_axis.tdata[(k - int'(carry_cnt))*SAMP_W +: SAMP_W];
      end
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      carry_d      = carry_q;
      flush_n_d    = flush_n_q;
      flush_user_d = flush_user_q;
      o_err_d      = 1'b0;
      emit         = 1'b0;
      e_data       = i_axis.tdata;
      e_user       = i_axis.tuser;
      e_last       = 1'b0;
      e_n          = '0;
      unique case (state_q)
         SOP: if (in_fire) begin
            off_d = i_offset;
            if (i_offset == '0) begin
               emit   = 1'b1;
               e_last = i_axis.tlast;
               e_n    = i_axis.tlast ? i_axis.last_n : '0;
               if (!i_axis.tlast) state_d = RUN;
            end else if (!i_axis.tlast) begin
               carry_d = shifted;
               state_d = RUN;
            end else if (n_full > {1'b0, i_offset}) begin
               emit   = 1'b1;
               e_data = shifted;
               e_last = 1'b1;
               e_n    = SHIFT_W'(n_full - {1'b0, i_offset});
            end else begin
               // single-beat packet holds no sample past the offset
               o_err_d = 1'b1;
`ifdef UNALIGN_SAMPLES_ZERO_PAD_EN
               carry_d = '0;
`endif
            end
         end
         RUN: if (in_fire) begin
            emit = 1'b1;
            if (off_q == '0) begin
               e_last = i_axis.tlast;
               e_n    = i_axis.tlast ? i_axis.last_n : '0;
               if (i_axis.tlast) state_d = SOP;
            end else begin
               e_data = merged;
               if (!i_axis.tlast) begin
                  carry_d = shifted;
               end else if (fill_cnt <= SPC_F) begin
                  e_last  = 1'b1;
                  e_n     = SHIFT_W'(fill_cnt);
                  state_d = SOP;
               end else begin
                  carry_d      = shifted;
                  flush_n_d    = SHIFT_W'(n_full - {1'b0, off_q});
                  flush_user_d = i_axis.tuser;
                  state_d      = FLUSH;
               end
            end
         end
         FLUSH: if (load) begin
            emit    = 1'b1;
            e_data  = carry_q;
            e_user  = flush_user_q;
            e_last  = 1'b1;
            e_n     = flush_n_q;
            state_d = SOP;
         end
         default: state_d = SOP;
      endcase
   end

   always_comb begin
      o_tvalid_d = o_tvalid_q;
      o_tdata_d  = o_tdata_q;
      o_tuser_d  = o_tuser_q;
      o_tlast_d  = o_tlast_q;
      o_last_n_d = o_last_n_q;
      if (load) o_tvalid_d = emit;
      if (emit) begin
`ifdef UNALIGN_SAMPLES_ZERO_PAD_EN
         o_tdata_d = e_last ? pad_lanes(e_data, e_n) : e_data;
`else
         o_tdata_d = e_data;
`endif
         o_tuser_d  = e_user;
         o_tlast_d  = e_last;
         o_last_n_d = e_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= SOP;
         off_q        <= '0;
         carry_q      <= '0;
         flush_n_q    <= '0;
         flush_user_q <= '0;
         o_tdata_q    <= '0;
         o_tuser_q    <= '0;
         o_tlast_q    <= 1'b0;
         o_last_n_q   <= '0;
         o_tvalid_q   <= 1'b0;
         o_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         carry_q      <= carry_d;
         flush_n_q    <= flush_n_d;
         flush_user_q <= flush_user_d;
         o_tdata_q    <= o_tdata_d;
         o_tuser_q    <= o_tuser_d;
         o_tlast_q    <= o_tlast_d;
         o_last_n_q   <= o_last_n_d;
         o_tvalid_q   <= o_tvalid_d;
         o_err_q      <= o_err_d;
      end
   end

   assign o_axis.tdata  = o_tdata_q;
   assign o_axis.tuser  = o_tuser_q;
   assign o_axis.tlast  = o_tlast_q;
   assign o_axis.last_n = o_last_n_q;
   assign o_axis.tvalid = o_tvalid_q;
   assign o_err         = o_err_q;
endmodule

// File: tb/tb_unalign_samples.sv
// Bench for unalign_samples: directed table of packet shapes, hand-written corner sequences,
// then random packets under random output back-pressure against a sample-level packing model.
module tb_unalign_samples;
   localparam int SAMP_W  = 32;
   localparam int SPC     = 4;
   localparam int USER_W  = 1;
   localparam int DATA_W  = SPC * SAMP_W;
   localparam int SHIFT_W = $clog2(SPC);

   typedef struct {
      logic [DATA_W-1:0]  data;
      logic [USER_W-1:0]  user;
      logic               last;
      logic [SHIFT_W-1:0] last_n;
      int                 cnt;
   } beat_t;

   typedef struct {
      int offset;
      int nbeats;
      int last_n;
      int exp_beats;
      int exp_last_n;
      int exp_err;
   } vec_t;

   logic               clk;
   logic               rst_n;
   logic [SHIFT_W-1:0] i_offset;
   logic               o_err;

   unalign_samples_if #(.SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W)) i_axis_if ();
   unalign_samples_if #(.SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W)) o_axis_if ();

   unalign_samples #(.SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_offset (i_offset),
      .i_axis   (i_axis_if),
      .o_axis   (o_axis_if),
      .o_err    (o_err)
   );

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int err_expected = 0;
   int beats_seen = 0;
   int stall_cycles = 0;
   int pkt_num = 0;
   int ready_mode = 0;
   logic [SHIFT_W-1:0] last_seen_n = '0;
   beat_t exp_q[$];

   logic [DATA_W-1:0] pkt_data[8];
   logic [USER_W-1:0] pkt_user[8];
   int pkt_beats, pkt_off, pkt_lastn;

   vec_t vecs[10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // output back-pressure: 0 always ready, 1 random, 2 stalled
   initial begin
      o_axis_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       o_axis_if.tready = 1'b1;
            1:       o_axis_if.tready = 1'($urandom_range(0, 1));
            default: o_axis_if.tready = 1'b0;
         endcase
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] laneMask(input int cnt);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int k = 0; k < cnt; k++) m[k*SAMP_W +: SAMP_W] = '1;
      return m;
   endfunction

   task automatic compareBeat();
      beat_t e;
      logic [DATA_W-1:0] m;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_beat: got %h, expected no beat", o_axis_if.tdata);
         return;
      end
      e = exp_q.pop_front();
`ifdef UNALIGN_SAMPLES_ZERO_PAD_EN
      m = e.last ? '1 : laneMask(e.cnt);
`else
      m = laneMask(e.cnt);
`endif
      checkOutput("beat_data", o_axis_if.tdata & m, e.data & m);
      checkOutput("beat_tlast", DATA_W'(o_axis_if.tlast), DATA_W'(e.last));
      checkOutput("beat_tuser", DATA_W'(o_axis_if.tuser), DATA_W'(e.user));
      if (e.last) checkOutput("beat_last_n", DATA_W'(o_axis_if.last_n), DATA_W'(e.last_n));
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (o_err === 1'b1) err_seen++;
         if (o_axis_if.tvalid === 1'b1 && o_axis_if.tready === 1'b1) begin
            beats_seen++;
            if (o_axis_if.tlast) last_seen_n = o_axis_if.last_n;
            compareBeat();
         end
      end
   end

   task automatic buildPacket(input int off, input int nb, input int ln);
      pkt_num++;
      pkt_off   = off;
      pkt_beats = nb;
      pkt_lastn = ln;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < SPC; k++)
            pkt_data[b][k*SAMP_W +: SAMP_W] = {16'(pkt_num), 16'(b*SPC + k)};
         pkt_user[b] = USER_W'($urandom);
      end
   endtask

   // flatten the packet to a sample stream, drop the offset, repack into full words
   task automatic modelPacket();
      logic [SAMP_W-1:0] samp[$];
      int src[$];
      int total, cnt;
      beat_t e;
      for (int b = 0; b < pkt_beats; b++) begin
         cnt = (b == pkt_beats - 1) ? ((pkt_lastn == 0) ? SPC : pkt_lastn) : SPC;
         for (int k = 0; k < cnt; k++) begin
            samp.push_back(pkt_data[b][k*SAMP_W +: SAMP_W]);
            src.push_back(b);
         end
      end
      for (int i = 0; i < pkt_off; i++) begin
         if (samp.size() > 0) begin
            void'(samp.pop_front());
            void'(src.pop_front());
         end
      end
      total = samp.size();
      if (total == 0) begin
         err_expected++;
         return;
      end
      for (int w = 0; w * SPC < total; w++) begin
         cnt = (total - w * SPC < SPC) ? (total - w * SPC) : SPC;
         e.data = '0;
         for (int k = 0; k < cnt; k++) e.data[k*SAMP_W +: SAMP_W] = samp[w*SPC + k];
         e.user   = pkt_user[src[w*SPC + cnt - 1]];
         e.last   = ((w + 1) * SPC >= total);
         e.last_n = e.last ? SHIFT_W'(cnt % SPC) : '0;
         e.cnt    = cnt;
         exp_q.push_back(e);
      end
   endtask

   task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [USER_W-1:0] user,
                                input logic last, input logic [SHIFT_W-1:0] ln,
                                input logic [SHIFT_W-1:0] off);
      int waited = 0;
      i_axis_if.tdata  = data;
      i_axis_if.tuser  = user;
      i_axis_if.tlast  = last;
      i_axis_if.last_n = ln;
      i_offset         = off;
      i_axis_if.tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (i_axis_if.tready === 1'b1) break;
         stall_cycles++;
         waited++;
         if (waited > 2000) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_accept_timeout: got tready=0 for %0d cycles, expected acceptance", waited);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // offset and last_n are randomised on beats where the design must ignore them
   task automatic sendPacket(input int first_beat);
      logic last;
      for (int b = first_beat; b < pkt_beats; b++) begin
         last = (b == pkt_beats - 1);
         applyStimulus(pkt_data[b], pkt_user[b], last,
                       last ? SHIFT_W'(pkt_lastn) : SHIFT_W'($urandom),
                       (b == 0) ? SHIFT_W'(pkt_off) : SHIFT_W'($urandom));
      end
      i_axis_if.tvalid = 1'b0;
   endtask

   task automatic waitDrain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || o_axis_if.tvalid === 1'b1) && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (n >= limit) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int b0, e0;
      vecs[0] = '{0, 3, 0, 3, 0, 0};
      vecs[1] = '{2, 3, 0, 3, 2, 0};
      vecs[2] = '{3, 2, 1, 1, 2, 0};
      vecs[3] = '{2, 1, 1, 0, 0, 1};
      vecs[4] = '{2, 1, 3, 1, 1, 0};
      vecs[5] = '{1, 2, 0, 2, 3, 0};
      vecs[6] = '{3, 1, 0, 1, 1, 0};
      vecs[7] = '{1, 2, 1, 1, 0, 0};
      vecs[8] = '{0, 1, 2, 1, 2, 0};
      vecs[9] = '{3, 1, 3, 0, 0, 1};

      rst_n            = 1'b0;
      i_offset         = '0;
      i_axis_if.tdata  = '0;
      i_axis_if.tuser  = '0;
      i_axis_if.tlast  = 1'b0;
      i_axis_if.last_n = '0;
      i_axis_if.tvalid = 1'b0;
      ready_mode       = 0;
      repeat (3) @(negedge clk);

      checkOutput("reset_tvalid", DATA_W'(o_axis_if.tvalid), '0);
      checkOutput("reset_tlast", DATA_W'(o_axis_if.tlast), '0);
      checkOutput("reset_tdata", o_axis_if.tdata, '0);
      checkOutput("reset_tuser", DATA_W'(o_axis_if.tuser), '0);
      checkOutput("reset_last_n", DATA_W'(o_axis_if.last_n), '0);
      checkOutput("reset_err", DATA_W'(o_err), '0);
      checkOutput("reset_i_tready", DATA_W'(i_axis_if.tready), DATA_W'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] directed packet table");
      for (int v = 0; v < 10; v++) begin
         buildPacket(vecs[v].offset, vecs[v].nbeats, vecs[v].last_n);
         b0 = beats_seen;
         e0 = err_seen;
         modelPacket();
         sendPacket(0);
         waitDrain(200);
         checkOutput($sformatf("vec%0d_beats", v), DATA_W'(beats_seen - b0), DATA_W'(vecs[v].exp_beats));
         checkOutput($sformatf("vec%0d_err", v), DATA_W'(err_seen - e0), DATA_W'(vecs[v].exp_err));
         if (vecs[v].exp_beats > 0)
            checkOutput($sformatf("vec%0d_last_n", v), DATA_W'(last_seen_n), DATA_W'(vecs[v].exp_last_n));
         @(posedge clk);
         #1;
      end

      $display("[TB] flush bubble and pass-through throughput");
      buildPacket(2, 3, 0);
      modelPacket();
      sendPacket(0);
      @(negedge clk);
      checkOutput("flush_i_tready_low", DATA_W'(i_axis_if.tready), '0);
      @(negedge clk);
      checkOutput("flush_i_tready_back", DATA_W'(i_axis_if.tready), DATA_W'(1));
      waitDrain(200);
      @(posedge clk);
      #1;
      buildPacket(0, 3, 0);
      modelPacket();
      stall_cycles = 0;
      sendPacket(0);
      checkOutput("passthru_stalls", DATA_W'(stall_cycles), '0);
      @(negedge clk);
      checkOutput("passthru_i_tready", DATA_W'(i_axis_if.tready), DATA_W'(1));
      waitDrain(200);

      $display("[TB] reset in mid-packet");
      @(posedge clk);
      #1 ready_mode = 2;
      @(posedge clk);
      #2;
      buildPacket(2, 3, 0);
      applyStimulus(pkt_data[0], pkt_user[0], 1'b0, '0, 2'd2);
      applyStimulus(pkt_data[1], pkt_user[1], 1'b0, '0, 2'd1);
      i_axis_if.tvalid = 1'b0;
      @(negedge clk);
      checkOutput("abort_held_valid", DATA_W'(o_axis_if.tvalid), DATA_W'(1));
      #1 rst_n = 1'b0;
      #1;
      checkOutput("abort_async_tvalid", DATA_W'(o_axis_if.tvalid), '0);
      checkOutput("abort_async_tdata", o_axis_if.tdata, '0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ready_mode = 0;
      @(posedge clk);
      #1;
      buildPacket(0, 2, 2);
      b0 = beats_seen;
      modelPacket();
      sendPacket(0);
      waitDrain(200);
      checkOutput("post_reset_beats", DATA_W'(beats_seen - b0), DATA_W'(2));

      $display("[TB] random packets with random back-pressure");
      @(posedge clk);
      #1 ready_mode = 1;
      for (int p = 0; p < 1000; p++) begin
         buildPacket($urandom_range(0, SPC-1), $urandom_range(1, 4), $urandom_range(0, SPC-1));
         modelPacket();
         sendPacket(0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      waitDrain(5000);

      checkOutput("final_queue_empty", DATA_W'(exp_q.size()), '0);
      checkOutput("final_err_count", DATA_W'(err_seen), DATA_W'(err_expected));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
